// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use bubbles, counted multiply stalls in EX,
// a multi-cycle branch flush window and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int unsigned REG_ADDR_W      = 5,
    parameter int unsigned MUL_CYCLES      = 4,
    parameter int unsigned BR_FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [1:0]            Branch,
    input  logic                  IDEXMemRead,
    input  logic [REG_ADDR_W-1:0] IDEXRt,
    input  logic [REG_ADDR_W-1:0] IFIDRs,
    input  logic [REG_ADDR_W-1:0] IFIDRt,
    input  logic                  IFIDUsesRt,
    input  logic                  MulStart,
    output logic                  PCWrite,
    output logic                  IFIDWrite,
    output logic                  IFIDFlush,
    output logic                  IDEXWrite,
    output logic                  IDEXFlush,
    output logic                  EXMEMFlush,
    output logic                  MulBusy,
    output logic [CNT_W-1:0]      StallCycles
);

    localparam int unsigned MCNT_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES - 1) : 1;
    localparam int unsigned BCNT_W = (BR_FLUSH_CYCLES > 2) ? $clog2(BR_FLUSH_CYCLES - 1) : 1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_WAIT = 2'd1,
        BR_FLUSH = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [MCNT_W-1:0]   mcnt, mcnt_nxt;
    logic [BCNT_W-1:0]   bcnt, bcnt_nxt;
    logic                load_use;
    logic                issue;

    assign load_use = IDEXMemRead && (IDEXRt != '0) &&
                      ((IDEXRt == IFIDRs) || (IFIDUsesRt && (IDEXRt == IFIDRt)));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= RUN;
            mcnt  <= '0;
            bcnt  <= '0;
        end else begin
            state <= state_nxt;
            mcnt  <= mcnt_nxt;
            bcnt  <= bcnt_nxt;
        end
    end

    // Next state and controls; issue marks cycles where the normal RUN rules apply.
    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IDEXWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXFlush  = 1'b0;
        EXMEMFlush = 1'b0;
        MulBusy    = 1'b0;
        state_nxt  = state;
        mcnt_nxt   = mcnt;
        bcnt_nxt   = bcnt;
        issue      = 1'b0;

        if (!Reset) begin
            case (state)
                RUN: begin
                    if (MulStart && (MUL_CYCLES > 1)) begin
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        IDEXWrite  = 1'b0;
                        EXMEMFlush = 1'b1;
                        MulBusy    = 1'b1;
                        mcnt_nxt   = MCNT_W'(MUL_CYCLES - 2);
                        state_nxt  = MUL_WAIT;
                    end else begin
                        issue = 1'b1;
                    end
                end
                MUL_WAIT: begin
                    if (mcnt != '0) begin
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        IDEXWrite  = 1'b0;
                        EXMEMFlush = 1'b1;
                        MulBusy    = 1'b1;
                        mcnt_nxt   = mcnt - MCNT_W'(1);
                    end else begin
                        issue     = 1'b1;
                        state_nxt = RUN;
                    end
                end
                BR_FLUSH: begin
                    IFIDFlush = 1'b1;
                    if (bcnt == '0) begin
                        state_nxt = RUN;
                    end else begin
                        bcnt_nxt = bcnt - BCNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase

            if (issue) begin
                if (load_use) begin
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    IDEXFlush = 1'b1;
                end else if (Branch != 2'b00) begin
                    IFIDFlush = 1'b1;
                    if (BR_FLUSH_CYCLES > 1) begin
                        bcnt_nxt  = BCNT_W'(BR_FLUSH_CYCLES - 2);
                        state_nxt = BR_FLUSH;
                    end
                end
            end
        end
    end

    // Saturating count of cycles with the PC held.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            StallCycles <= '0;
        end else if (!PCWrite && (StallCycles != '1)) begin
            StallCycles <= StallCycles + CNT_W'(1);
        end
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard controller for the 5-stage MIPS datapath, sitting beside the IF/ID and ID/EX registers and driving the PC, IF/ID and ID/EX write and flush controls.

- Generalises the current combinational hazard logic with three features:
  - load-use detection with an "rt is a source" qualifier and a $zero exclusion;
  - a counted multi-cycle multiply stall (`MUL_CYCLES`) that holds the multiply in EX;
  - a configurable branch flush window (`BR_FLUSH_CYCLES`).
- A saturating stall-cycle counter is included for performance measurement.

## Interface

Parameters:
- `REG_ADDR_W`, default 5: register specifier width.
- `MUL_CYCLES`, default 4: EX-stage occupancy of a multiply in cycles. Legal range is ≥1; 1 means no stall.
- `BR_FLUSH_CYCLES`, default 1: consecutive cycles IF/ID is flushed on a taken branch. Legal range is ≥1.
- `CNT_W`, default 16: width of the stall counter.

Ports:
- `Clk`  in  1  clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Branch`  in  2  nonzero means a taken branch or jump resolved in ID this cycle.
- `IDEXMemRead`  in  1  instruction in ID/EX is a load.
- `IDEXRt`  in  `REG_ADDR_W`  load destination in ID/EX.
- `IFIDRs`  in  `REG_ADDR_W`  rs of the instruction in ID.
- `IFIDRt`  in  `REG_ADDR_W`  rt of the instruction in ID.
- `IFIDUsesRt`  in  1  instruction in ID reads rt as a source.
- `MulStart`  in  1  instruction in ID/EX (now in EX) is a multiply.
- `PCWrite`  out  1  PC load enable.
- `IFIDWrite`  out  1  IF/ID load enable.
- `IFIDFlush`  out  1  IF/ID clear to bubble.
- `IDEXWrite`  out  1  ID/EX load enable.
- `IDEXFlush`  out  1  ID/EX clear to bubble.
- `EXMEMFlush`  out  1  insert a bubble into EX/MEM.
- `MulBusy`  out  1  this cycle is a multiply stall cycle.
- `StallCycles`  out  `CNT_W`  saturating count of cycles with `PCWrite`=0.

## Operation

**Outputs.**
- All controls are combinational from the registered state plus the current inputs.
- Idle values: `PCWrite`=`IFIDWrite`=`IDEXWrite`=1; `IFIDFlush`=`IDEXFlush`=`EXMEMFlush`=`MulBusy`=0.

**States.**
- `RUN`: normal issue.
- `MUL_WAIT`: a multiply is held in EX; down-counter `mcnt` is active.
- `BR_FLUSH`: flush window; down-counter `bcnt` is active.

**Decision priority in `RUN`** (first match wins):
1. **Multiply.** If `MulStart` and `MUL_CYCLES`>1:
   - Stall cycle: `PCWrite`=`IFIDWrite`=`IDEXWrite`=0, `EXMEMFlush`=1, `MulBusy`=1.
   - Load `mcnt`=`MUL_CYCLES`-2 and go to `MUL_WAIT`.
   - With `MUL_CYCLES`=1, `MulStart` has no effect.
2. **Load-use.** Condition: `IDEXMemRead` AND `IDEXRt`≠0 AND (`IDEXRt`==`IFIDRs` OR (`IFIDUsesRt` AND `IDEXRt`==`IFIDRt`)).
   - Response: `PCWrite`=`IFIDWrite`=0, `IDEXFlush`=1.
   - Single cycle; no state change.
3. **Branch.** If `Branch`≠0:
   - `IFIDFlush`=1; `PCWrite` stays 1 so the target loads.
   - If `BR_FLUSH_CYCLES`>1, load `bcnt`=`BR_FLUSH_CYCLES`-2 and go to `BR_FLUSH`.
4. Otherwise, idle values.

**`MUL_WAIT`.**
- While `mcnt`≠0: stall values as in priority 1, and decrement `mcnt`.
- When `mcnt`==0 (release cycle):
  - `MulBusy`=0 and `EXMEMFlush`=0, so the multiply result advances.
  - Controls are decided exactly as in `RUN` priorities 2–4, with `MulStart` ignored.
  - Next state is `RUN`, or `BR_FLUSH` if the branch rule selects it.
- `MulStart` is ignored throughout `MUL_WAIT`, because the held multiply keeps asserting it.
- `Branch` and load-use are ignored on stall cycles.

**`BR_FLUSH`.**
- `IFIDFlush`=1, all other controls idle.
- `Branch`, `MulStart` and load-use are ignored.
- Decrement `bcnt`; exit to `RUN` after the cycle with `bcnt`==0.

**`StallCycles`.**
- Increments on every cycle where `PCWrite`=0 and `Reset`=0.
- Saturates at all-ones; never wraps.

## Timing

- **Reset.** While `Reset`=1, outputs are forced to idle values regardless of inputs. The next state is `RUN` with `mcnt`=`bcnt`=0 and `StallCycles`=0.
- **Reset mid-operation.** Reset during `MUL_WAIT` or `BR_FLUSH` abandons the operation; the first cycle after reset is `RUN`.
- **Multiply stall length.** A multiply entering EX in cycle t is stalled for cycles t..t+`MUL_CYCLES`-2 (exactly `MUL_CYCLES`-1 stall cycles) and released in cycle t+`MUL_CYCLES`-1.
- **Load-use stall.** Exactly one bubble per hazard. The hazard clears the next cycle because ID/EX then holds the bubble.
- **Branch flush.** A taken branch in cycle t flushes IF/ID in cycles t..t+`BR_FLUSH_CYCLES`-1.
- **Simultaneous events.**
  - Load-use with a branch: the stall wins; the branch is re-evaluated the next cycle, when it is still held in ID.
  - `MulStart` with load-use: the multiply stall wins.

## Test plan

- **Idle.** Reset, then 5 cycles with all inputs 0 → all idle values; `StallCycles`=0.
- **Load-use.**
  - `IDEXMemRead`=1, `IDEXRt`=5, `IFIDRs`=5 → one cycle of `PCWrite`=0, `IFIDWrite`=0, `IDEXFlush`=1; `StallCycles`=1.
  - Repeat with `IDEXRt`=0 → no stall.
  - Repeat with `IFIDRt`=5, `IFIDUsesRt`=0 → no stall.
- **Multiply** (`MUL_CYCLES`=4).
  - `MulStart` held for 4 cycles → `MulBusy`=1, `IDEXWrite`=0, `EXMEMFlush`=1 for exactly 3 cycles, release on the 4th.
  - `StallCycles` ends at 3.
- **Branch** (`BR_FLUSH_CYCLES`=2).
  - `Branch`=1 for one cycle → `IFIDFlush`=1 for 2 cycles, `PCWrite`=1 throughout.
  - A second `Branch` during the window is ignored.
- **Priority.**
  - Load-use and `Branch`=1 in the same cycle → stall only, then flush the following cycle.
  - `Branch` asserted on the `MUL_WAIT` release cycle → `IFIDFlush`=1 on that cycle.
- **Reset mid-operation and saturation.**
  - `Reset` during the second stall cycle of a multiply → idle outputs, `RUN` afterwards.
  - With `CNT_W`=4, 20 load-use stalls → `StallCycles`=15.
